// File: rtl/mul_accumulator.sv
// mul_accumulator: sums fixed-length groups of multiplier products into one acc_w-bit result with a sticky overflow flag.
module mul_accumulator #(
    parameter int n     = 8,
    parameter int len   = 4,
    parameter int acc_w = 2 * n + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [2*n-1:0]   prod,
    input  logic             prod_signed,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [acc_w-1:0] sum,
    output logic             sum_signed,
    output logic             sum_ovf
);
    localparam int cw = $clog2(len) + 1;
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
    state_t state, state_nx;
    logic [cw-1:0] cnt;
    logic [acc_w-1:0] acc, ext_prod;
    logic [acc_w:0] add_full;
    logic grp_signed, ovf, take, sgn, last, add_ovf;
    assign prod_ready = state != OUT;
    assign sum_valid  = state == OUT;
    assign sum        = acc;
    assign sum_signed = grp_signed;
    assign sum_ovf    = ovf;
    always_comb begin
        take     = prod_valid && prod_ready;
        sgn      = (state == IDLE) ? prod_signed : grp_signed;
        ext_prod = sgn ? acc_w'($signed(prod)) : acc_w'(prod);
        add_full = {1'b0, acc} + {1'b0, ext_prod};
        add_ovf  = grp_signed ? (acc[acc_w-1] == ext_prod[acc_w-1]) && (add_full[acc_w-1] != acc[acc_w-1])
                              : add_full[acc_w];
        last     = (state == IDLE) ? (len == 1) : (cnt == cw'(len - 1));
        state_nx = state;
        case (state)
            IDLE:    state_nx = take ? (last ? OUT : ACC) : IDLE;
            ACC:     state_nx = (take && last) ? OUT : ACC;
            OUT:     state_nx = sum_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            grp_signed <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (state == IDLE) begin
                    grp_signed <= prod_signed;
                    acc        <= ext_prod;
                    ovf        <= 1'b0;
                end else begin
                    acc <= add_full[acc_w-1:0];
                    ovf <= ovf | add_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_accumulator.sv
// tb_mul_accumulator: drives two accumulators (acc_w 12 and 8) in lockstep against an arithmetic reference model.
module tb_mul_accumulator;
    logic clk = 0, rst_n = 0, prod_valid = 0, prod_signed = 0, sum_ready = 1;
    logic [7:0] prod = 0;
    logic rdy_a, val_a, sgn_a, ovf_a, rdy_b, val_b, sgn_b, ovf_b;
    logic [11:0] sum_a;
    logic [7:0] sum_b;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    mul_accumulator #(.n(4), .len(4), .acc_w(12)) dut_a (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_ready(rdy_a), .prod(prod),
        .prod_signed(prod_signed), .sum_valid(val_a), .sum_ready(sum_ready), .sum(sum_a),
        .sum_signed(sgn_a), .sum_ovf(ovf_a));
    mul_accumulator #(.n(4), .len(4), .acc_w(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_ready(rdy_b), .prod(prod),
        .prod_signed(prod_signed), .sum_valid(val_b), .sum_ready(sum_ready), .sum(sum_b),
        .sum_signed(sgn_b), .sum_ovf(ovf_b));
    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // Running sum kept in the representable range of w bits; any add leaving that range overflows.
    function automatic void model(input logic [7:0] p[4], input bit sgn, input int w, output longint s, output bit o);
        longint a = 0, lo, hi, m, v;
        m  = longint'(1) << w;
        lo = sgn ? -(m / 2) : 0;
        hi = sgn ? m / 2 - 1 : m - 1;
        o  = 0;
        for (int i = 0; i < 4; i++) begin
            v = sgn ? longint'($signed(p[i])) : longint'(p[i]);
            a += v;
            if (a < lo || a > hi) begin
                o = 1;
                a = (((a - lo) % m) + m) % m + lo;
            end
        end
        s = a & (m - 1);
    endfunction
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy_a"}, rdy_a, 1); chk({tag, "_val_a"}, val_a, 0); chk({tag, "_sum_a"}, sum_a, 0);
        chk({tag, "_sgn_a"}, sgn_a, 0); chk({tag, "_ovf_a"}, ovf_a, 0);
        chk({tag, "_rdy_b"}, rdy_b, 1); chk({tag, "_val_b"}, val_b, 0); chk({tag, "_sum_b"}, sum_b, 0);
    endtask
    task automatic run_group(input logic [7:0] p[4], input bit sgn, input bit gaps, input int hold);
        longint s12, s8;
        bit o12, o8;
        model(p, sgn, 12, s12, o12);
        model(p, sgn, 8, s8, o8);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    prod_valid = 0; prod = 8'($urandom); prod_signed = 1'($urandom);
                    @(negedge clk);
                    chk("gap_val", val_a, 0);
                end
            end
            prod_valid = 1; prod = p[i]; prod_signed = (i == 0) ? sgn : ~sgn;
            @(negedge clk);
        end
        prod_valid = 0;
        chk("lat_val_a", val_a, 1); chk("lat_val_b", val_b, 1); chk("out_rdy", rdy_a, 0);
        chk("sum_a", sum_a, s12); chk("ovf_a", ovf_a, o12); chk("sgn_a", sgn_a, sgn);
        chk("sum_b", sum_b, s8);  chk("ovf_b", ovf_b, o8);  chk("sgn_b", sgn_b, sgn);
        if (hold > 0) begin
            sum_ready = 0;
            prod_valid = 1; prod = 8'hFF; prod_signed = 1;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("hold_val", val_a, 1); chk("hold_rdy", rdy_a, 0);
                chk("hold_sum_a", sum_a, s12); chk("hold_sum_b", sum_b, s8);
            end
            prod_valid = 0;
            sum_ready = 1;
        end
        @(negedge clk);
        chk("post_val", val_a, 0); chk("post_rdy", rdy_a, 1); chk("post_rdy_b", rdy_b, 1);
    endtask
    initial begin
        logic [7:0] p[4];
        #3 check_reset_outputs("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1;
        p = '{8'd225, 8'd225, 8'd225, 8'd225}; run_group(p, 0, 0, 0);
        p = '{8'd64, 8'hC8, 8'd64, 8'hC8};    run_group(p, 1, 0, 0);
        p = '{8'hC8, 8'hC8, 8'hC8, 8'hC8};    run_group(p, 1, 0, 0);
        p = '{8'd225, 8'd225, 8'd0, 8'd0};    run_group(p, 0, 0, 0);
        p = '{8'd64, 8'd64, 8'd64, 8'd64};    run_group(p, 1, 0, 0);
        p = '{8'd1, 8'd1, 8'd1, 8'd1};        run_group(p, 0, 0, 5);
        p = '{8'h80, 8'h7F, 8'hF0, 8'h05};    run_group(p, 1, 1, 0);
        for (int g = 0; g < 30; g++) begin
            for (int i = 0; i < 4; i++) p[i] = 8'($urandom);
            run_group(p, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
        prod_valid = 1; prod = 8'd1; prod_signed = 0;
        repeat (2) @(negedge clk);
        prod_valid = 0;
        chk("mid_sum_a", sum_a, 2);
        #2 rst_n = 0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1;
        p = '{8'd1, 8'd1, 8'd1, 8'd1}; run_group(p, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
